// File: rtl/fp_seq_div_if.sv
// Start/done handshake and operand/result bus of the sequential FP divider.
// The controller drives the master side; the divider sits on the slave side.
interface fp_seq_div_if;
   logic        startDiv;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] result;
   logic        doneDiv;
   logic        divZero;

   modport master (
      output startDiv, A, B,
      input  result, doneDiv, divZero
   );

   modport slave (
      input  startDiv, A, B,
      output result, doneDiv, divZero
   );
endinterface

// File: rtl/fp_seq_div.sv
// Sequential IEEE754 single-precision divider (A / B), normalized operands only.
// The quotient is truncated and comes from a 25-step restoring divider.
module fp_seq_div #(
   parameter int unsigned ITER = 25
) (
   input  logic         clk,
   input  logic         rst,
   fp_seq_div_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, INIT, LOAD, DIV} state_t;

   state_t      state, state_next;
   logic        done;

   logic        a_sign, b_sign;
   logic [7:0]  a_exp, b_exp;
   logic [23:0] mb;
   logic [24:0] rem;
   logic [23:0] quo;
   logic [4:0]  cnt;
   logic [31:0] result_r;
   logic        div_zero;

   logic        qbit;
   logic [24:0] quo_next;
   logic        last;
   logic signed [9:0] e;
   logic [22:0] mant;
   logic        sign;
   logic [31:0] res_next;
   logic        dz_next;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      done       = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            done = 1'b1;
            if (bus.startDiv) state_next = INIT;
         end
         INIT: if (!bus.startDiv) state_next = LOAD;
         LOAD: state_next = DIV;
         DIV: begin
            if (cnt == 5'(ITER - 1)) begin
               last       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The last quotient bit is folded in combinationally so the packed result
   // can be written on the same edge that takes it.
   always_comb begin
      qbit     = (rem >= {1'b0, mb});
      quo_next = {quo, qbit};
      sign     = a_sign ^ b_sign;
      e        = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127
                 - (quo_next[24] ? 10'sd0 : 10'sd1);
      mant     = quo_next[24] ? quo_next[23:1] : quo_next[22:0];
      dz_next  = 1'b0;
      if (a_exp == 8'd0 && b_exp == 8'd0)
         res_next = 32'h7FC0_0000;
      else if (a_exp == 8'd0)
         res_next = {sign, 31'd0};
      else if (b_exp == 8'd0) begin
         res_next = {sign, 8'hFF, 23'd0};
         dz_next  = 1'b1;
      end
      else if (e <= 10'sd0)
         res_next = {sign, 31'd0};
      else if (e >= 10'sd255)
         res_next = {sign, 8'hFF, 23'd0};
      else
         res_next = {sign, e[7:0], mant};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_sign   <= 1'b0;
         b_sign   <= 1'b0;
         a_exp    <= '0;
         b_exp    <= '0;
         mb       <= '0;
         rem      <= '0;
         quo      <= '0;
         cnt      <= '0;
         result_r <= '0;
         div_zero <= 1'b0;
      end
      else begin
         case (state)
            LOAD: begin
               a_sign <= bus.A[31];
               b_sign <= bus.B[31];
               a_exp  <= bus.A[30:23];
               b_exp  <= bus.B[30:23];
               mb     <= {1'b1, bus.B[22:0]};
               rem    <= {2'b01, bus.A[22:0]};
               quo    <= '0;
               cnt    <= '0;
            end
            DIV: begin
               rem <= (qbit ? rem - {1'b0, mb} : rem) << 1;
               quo <= quo_next[23:0];
               cnt <= cnt + 5'd1;
               if (last) begin
                  result_r <= res_next;
                  div_zero <= dz_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.doneDiv = done;
   assign bus.result  = result_r;
   assign bus.divZero = div_zero;

endmodule

// File: tb/tb_fp_seq_div.sv
// Self-checking bench for fp_seq_div: directed cases plus random operands
// compared against an integer-division reference model of the divider.
module tb_fp_seq_div;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   fp_seq_div_if bus ();

   fp_seq_div dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Quotient mantissa = floor(MA * 2^24 / MB), a 25-bit value in [2^23, 2^25).
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic dz);
      logic       s;
      int         ea, eb, ex;
      longint     ma, mb, q;
      logic [22:0] m;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      ma = longint'({1'b1, a[22:0]});
      mb = longint'({1'b1, b[22:0]});
      q  = (ma << 24) / mb;
      dz = 1'b0;
      if (q >= (64'sd1 <<< 24)) begin
         ex = ea - eb + 127;
         m  = 23'((q >> 1) & 64'h7FFFFF);
      end
      else begin
         ex = ea - eb + 126;
         m  = 23'(q & 64'h7FFFFF);
      end
      if (ea == 0 && eb == 0)  res = 32'h7FC0_0000;
      else if (ea == 0)        res = {s, 31'd0};
      else if (eb == 0) begin
         res = {s, 8'hFF, 23'd0};
         dz  = 1'b1;
      end
      else if (ex <= 0)        res = {s, 31'd0};
      else if (ex >= 255)      res = {s, 8'hFF, 23'd0};
      else                     res = {s, 8'(ex), m};
   endfunction

   // Holds start for three cycles, then counts edges from the one that sees it low.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input string tag, input bit scramble);
      logic [31:0] er;
      logic        edz;
      int          n;
      ref_div(a, b, er, edz);
      @(negedge clk);
      chk({tag, ".idle"}, 32'(bus.doneDiv), 32'd1);
      bus.A        = a;
      bus.B        = b;
      bus.startDiv = 1'b1;
      @(negedge clk);
      chk({tag, ".busy"}, 32'(bus.doneDiv), 32'd0);
      @(negedge clk);
      @(negedge clk);
      bus.startDiv = 1'b0;
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (scramble && n == 2) begin
            bus.A = $urandom;
            bus.B = $urandom;
         end
         if (bus.doneDiv) break;
      end
      chk({tag, ".lat"}, 32'(n), 32'd27);
      chk({tag, ".res"}, bus.result, er);
      chk({tag, ".dz"}, 32'(bus.divZero), 32'(edz));
   endtask

   function automatic logic [31:0] rnd_norm(input int lo, input int hi);
      logic [31:0] v;
      v = $urandom;
      v[30:23] = 8'($urandom_range(hi, lo));
      return v;
   endfunction

   initial begin
      int n;
      bus.startDiv = 1'b0;
      bus.A        = '0;
      bus.B        = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.res", bus.result, 32'd0);
      chk("rst.done", 32'(bus.doneDiv), 32'd1);
      chk("rst.dz", 32'(bus.divZero), 32'd0);
      rst = 1'b1;

      run_op(32'h40C0_0000, 32'h4000_0000, "6/2", 1'b0);
      chk("6/2.const", bus.result, 32'h4040_0000);
      run_op(32'h3F80_0000, 32'h4040_0000, "1/3", 1'b0);
      chk("1/3.const", bus.result, 32'h3EAA_AAAA);
      run_op(32'hC0F0_0000, 32'h4020_0000, "-7.5/2.5", 1'b0);
      chk("-7.5/2.5.const", bus.result, 32'hC040_0000);
      run_op(32'h0000_0000, 32'h40A0_0000, "0/5", 1'b0);
      run_op(32'h40A0_0000, 32'h0000_0000, "5/0", 1'b0);
      chk("5/0.const", bus.result, 32'h7F80_0000);
      run_op(32'hC0A0_0000, 32'h0000_0000, "-5/0", 1'b0);
      run_op(32'h0000_0000, 32'h0000_0000, "0/0", 1'b0);
      run_op(32'h7F00_0000, 32'h3E80_0000, "ovf", 1'b0);
      run_op(32'h0080_0000, 32'h7F00_0000, "unf", 1'b0);

      // Abandon an operation mid-divide, with stale result and divZero set.
      run_op(32'h40A0_0000, 32'h0000_0000, "pre", 1'b0);
      @(negedge clk);
      bus.A        = 32'h40C0_0000;
      bus.B        = 32'h4000_0000;
      bus.startDiv = 1'b1;
      repeat (3) @(negedge clk);
      bus.startDiv = 1'b0;
      for (n = 0; n < 12; n++) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid.res", bus.result, 32'd0);
      chk("mid.done", 32'(bus.doneDiv), 32'd1);
      chk("mid.dz", 32'(bus.divZero), 32'd0);
      rst = 1'b1;
      run_op(32'h3F80_0000, 32'h4040_0000, "post", 1'b0);

      run_op(32'h40C0_0000, 32'h4000_0000, "stab", 1'b1);
      for (int i = 0; i < 6; i++)
         run_op(rnd_norm(1, 254), rnd_norm(1, 254), "rstab", 1'b1);

      for (int i = 0; i < 30; i++)
         run_op(rnd_norm(64, 190), rnd_norm(64, 190), "rnd", 1'b0);
      for (int i = 0; i < 10; i++)
         run_op(rnd_norm(200, 254), rnd_norm(1, 60), "rovf", 1'b0);
      for (int i = 0; i < 10; i++)
         run_op(rnd_norm(1, 60), rnd_norm(190, 254), "runf", 1'b0);
      for (int i = 0; i < 6; i++) begin
         logic [31:0] x;
         x = $urandom;
         x[30:23] = 8'd0;
         if (i % 2 == 0) run_op(x, rnd_norm(1, 254), "rz", 1'b0);
         else            run_op(rnd_norm(1, 254), x, "rdz", 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
